// File: rtl/sym_classifier.sv
// Byte FIFO + character-class decoder feeding the string-recognizer FSM, one symbol per paced pulse.
// Optional SYM_CLASSIFIER_STATS_EN adds popped-symbol and popped-NUL counters.
module sym_classifier #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_valid,
    output logic        o_error_verify,
    output logic        o_overflow,
`ifdef SYM_CLASSIFIER_STATS_EN
    output logic [15:0] o_sym_count,
    output logic [7:0]  o_str_count,
`endif
    output logic        o_start_stop,
    output logic        o_small_letter,
    output logic        o_capital_letter,
    output logic        o_number,
    output logic        o_hex_digit,
    output logic        o_punctuation_basic,
    output logic        o_punctuation_finance,
    output logic        o_parentheses,
    output logic        o_curly_braces,
    output logic        o_math_symbol,
    output logic        o_whitespace,
    output logic        o_vowel,
    output logic        o_consonant,
    output logic        o_other
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic [3:0]  r_gap;
    logic        r_valid, r_err, r_ovf;
    logic [13:0] r_flags;

    logic        w_empty, w_full, w_pop, w_push;
    logic [7:0]  w_head;
    logic        w_ss, w_small, w_cap, w_num, w_hex, w_pb, w_pf;
    logic        w_paren, w_curly, w_math, w_ws, w_vowel, w_cons, w_other;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && (r_gap == 4'd0);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push  = i_rx_valid && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    always_comb begin
        w_ss    = (w_head == 8'h00);
        w_small = (w_head >= 8'h61) && (w_head <= 8'h7A);
        w_cap   = (w_head >= 8'h41) && (w_head <= 8'h5A);
        w_num   = (w_head >= 8'h30) && (w_head <= 8'h39);
        w_hex   = w_num || (w_head inside {[8'h41:8'h46], [8'h61:8'h66]});
        w_pb    = w_head inside {8'h2E, 8'h2C, 8'h3A, 8'h3B, 8'h21, 8'h3F, 8'h27, 8'h22};
        w_pf    = w_head inside {[8'h23:8'h26], 8'h40};
        w_paren = w_head inside {8'h28, 8'h29, 8'h5B, 8'h5D};
        w_curly = w_head inside {8'h7B, 8'h7D};
        w_math  = w_head inside {8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h5C, 8'h3D, 8'h3C, 8'h3E};
        w_ws    = w_head inside {8'h20, 8'h09, 8'h0A, 8'h0D};
        w_vowel = w_head inside {8'h61, 8'h65, 8'h69, 8'h6F, 8'h75,
                                 8'h41, 8'h45, 8'h49, 8'h4F, 8'h55};
        w_cons  = (w_small || w_cap) && !w_vowel;
        w_other = !(w_ss || w_small || w_cap || w_num || w_pb || w_pf || w_paren ||
                    w_curly || w_math || w_ws);
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_gap   <= 4'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_flags <= '0;
        end else begin
            r_valid <= w_pop;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_rx_valid && !w_push) begin
                r_ovf <= 1'b1;
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + 1'b1;
                r_gap   <= 4'(GAP);
                r_err   <= w_ss;
                r_flags <= {w_ss, w_small, w_cap, w_num, w_hex, w_pb, w_pf,
                            w_paren, w_curly, w_math, w_ws, w_vowel, w_cons, w_other};
            end else if (r_gap != 4'd0) begin
                r_gap <= r_gap - 4'd1;
            end
        end
    end

`ifdef SYM_CLASSIFIER_STATS_EN
    logic [15:0] r_sym_count;
    logic [7:0]  r_str_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sym_count <= 16'd0;
            r_str_count <= 8'd0;
        end else if (w_pop) begin
            if (r_sym_count != 16'hFFFF) begin
                r_sym_count <= r_sym_count + 16'd1;
            end
            if (w_ss) begin
                r_str_count <= r_str_count + 8'd1;
            end
        end
    end

    assign o_sym_count = r_sym_count;
    assign o_str_count = r_str_count;
`endif

    assign o_valid        = r_valid;
    assign o_error_verify = r_err;
    assign o_overflow     = r_ovf;

    assign {o_start_stop, o_small_letter, o_capital_letter, o_number, o_hex_digit,
            o_punctuation_basic, o_punctuation_finance, o_parentheses, o_curly_braces,
            o_math_symbol, o_whitespace, o_vowel, o_consonant, o_other} = r_flags;
endmodule

// File: tb/tb_sym_classifier.sv
// Directed bench for sym_classifier: instance a (DEPTH=8, GAP=1) and instance b (DEPTH=4, GAP=15).
module tb_sym_classifier;
    localparam logic [13:0] SS = 14'h2000, SMALL = 14'h1000, CAP = 14'h0800, NUM = 14'h0400;
    localparam logic [13:0] HEX = 14'h0200, PB = 14'h0100, PF = 14'h0080, PAREN = 14'h0040;
    localparam logic [13:0] CURLY = 14'h0020, MATH = 14'h0010, WS = 14'h0008;
    localparam logic [13:0] VOW = 14'h0004, CONS = 14'h0002, OTH = 14'h0001;

    logic       clk, rst;
    logic [7:0] a_data, b_data;
    logic       a_rxv, b_rxv;
    logic       a_valid, a_err, a_ovf, b_valid, b_err, b_ovf;
    logic [13:0] a_flags, b_flags;
`ifdef SYM_CLASSIFIER_STATS_EN
    logic [15:0] a_sym, b_sym;
    logic [7:0]  a_str, b_str;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  s_data  [16];
    logic [13:0] s_flags [16];
    int          s_n;

    sym_classifier #(.DEPTH(8), .GAP(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_rx_data(a_data), .i_rx_valid(a_rxv),
        .o_valid(a_valid), .o_error_verify(a_err), .o_overflow(a_ovf),
`ifdef SYM_CLASSIFIER_STATS_EN
        .o_sym_count(a_sym), .o_str_count(a_str),
`endif
        .o_start_stop(a_flags[13]), .o_small_letter(a_flags[12]),
        .o_capital_letter(a_flags[11]), .o_number(a_flags[10]), .o_hex_digit(a_flags[9]),
        .o_punctuation_basic(a_flags[8]), .o_punctuation_finance(a_flags[7]),
        .o_parentheses(a_flags[6]), .o_curly_braces(a_flags[5]), .o_math_symbol(a_flags[4]),
        .o_whitespace(a_flags[3]), .o_vowel(a_flags[2]), .o_consonant(a_flags[1]),
        .o_other(a_flags[0])
    );

    sym_classifier #(.DEPTH(4), .GAP(15)) u_b (
        .i_clk(clk), .i_rst(rst), .i_rx_data(b_data), .i_rx_valid(b_rxv),
        .o_valid(b_valid), .o_error_verify(b_err), .o_overflow(b_ovf),
`ifdef SYM_CLASSIFIER_STATS_EN
        .o_sym_count(b_sym), .o_str_count(b_str),
`endif
        .o_start_stop(b_flags[13]), .o_small_letter(b_flags[12]),
        .o_capital_letter(b_flags[11]), .o_number(b_flags[10]), .o_hex_digit(b_flags[9]),
        .o_punctuation_basic(b_flags[8]), .o_punctuation_finance(b_flags[7]),
        .o_parentheses(b_flags[6]), .o_curly_braces(b_flags[5]), .o_math_symbol(b_flags[4]),
        .o_whitespace(b_flags[3]), .o_vowel(b_flags[2]), .o_consonant(b_flags[1]),
        .o_other(b_flags[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Streams s_data[0..s_n-1] into instance a at one byte per cycle; GAP=1 gives pulses on
    // even cycles 2..2*s_n, and flags hold between pulses.
    task automatic run_a();
        int idx;
        for (int c = 0; c < 2 * s_n + 6; c++) begin
            a_rxv  = (c < s_n);
            a_data = (c < s_n) ? s_data[c] : 8'h00;
            check("a_valid", 32'(a_valid), 32'((c >= 2) && (c % 2 == 0) && (c <= 2 * s_n)));
            if (c >= 2) begin
                idx = (c - 2) / 2;
                if (idx > s_n - 1) idx = s_n - 1;
                check("a_flags", 32'(a_flags), 32'(s_flags[idx]));
            end
            tick();
        end
        a_rxv = 1'b0;
    endtask

    initial begin
        int         nb;
        logic [13:0] last_b;
        rst = 1'b0; a_rxv = 1'b0; b_rxv = 1'b0; a_data = 8'h00; b_data = 8'h00;
        tick();
        tick();
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_ovf", 32'(a_ovf), 32'd0);
        check("rst_flags", 32'(a_flags), 32'd0);
        rst = 1'b1;
        tick();

        // Single byte 0x24 pushed in cycle 5 appears in cycle 7 only.
        for (int c = 0; c < 10; c++) begin
            a_rxv  = (c == 5);
            a_data = 8'h24;
            check("lat_valid", 32'(a_valid), 32'(c == 7));
            if (c >= 7) begin
                check("lat_flags", 32'(a_flags), 32'(PF));
                check("lat_err", 32'(a_err), 32'd0);
            end
            tick();
        end
        a_rxv = 1'b0;

        s_n = 9;
        s_data[0] = 8'h00; s_flags[0] = SS;
        s_data[1] = 8'h24; s_flags[1] = PF;
        s_data[2] = 8'h31; s_flags[2] = NUM | HEX;
        s_data[3] = 8'h32; s_flags[3] = NUM | HEX;
        s_data[4] = 8'h33; s_flags[4] = NUM | HEX;
        s_data[5] = 8'h2B; s_flags[5] = MATH;
        s_data[6] = 8'h41; s_flags[6] = CAP | HEX | VOW;
        s_data[7] = 8'h42; s_flags[7] = CAP | HEX | CONS;
        s_data[8] = 8'h00; s_flags[8] = SS;
        run_a();
        check("str_err", 32'(a_err), 32'd1);
        check("str_ovf", 32'(a_ovf), 32'd0);

        s_n = 5;
        s_data[0] = 8'h7B; s_flags[0] = CURLY;
        s_data[1] = 8'h5C; s_flags[1] = MATH;
        s_data[2] = 8'h09; s_flags[2] = WS;
        s_data[3] = 8'hC8; s_flags[3] = OTH;
        s_data[4] = 8'h65; s_flags[4] = SMALL | HEX | VOW;
        run_a();
        check("mix_err", 32'(a_err), 32'd0);

        // Six pushes into a 4-deep FIFO: the first pop frees one slot, the sixth byte drops.
        nb = 0;
        last_b = '0;
        for (int c = 0; c < 100; c++) begin
            b_rxv  = (c < 6);
            b_data = 8'(8'h61 + c);
            if (b_valid) begin
                nb++;
                last_b = b_flags;
            end
            tick();
        end
        b_rxv = 1'b0;
        check("ovf_count", 32'(nb), 32'd5);
        check("ovf_last", 32'(last_b), 32'(SMALL | HEX | VOW));
        check("ovf_flag", 32'(b_ovf), 32'd1);
        check("a_ovf_clean", 32'(a_ovf), 32'd0);

        // Reset with bytes still queued in b.
        for (int c = 0; c < 4; c++) begin
            b_rxv  = 1'b1;
            b_data = 8'h00;
            tick();
        end
        b_rxv = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            check("mrst_valid", 32'(b_valid), 32'd0);
            tick();
        end
        check("mrst_flags", 32'(b_flags), 32'd0);
        check("mrst_err", 32'(b_err), 32'd0);
        check("mrst_ovf", 32'(b_ovf), 32'd0);
        check("mrst_a_flags", 32'(a_flags), 32'd0);

`ifdef SYM_CLASSIFIER_STATS_EN
        check("stat_rst", 32'(a_sym), 32'd0);
        s_n = 4;
        s_data[0] = 8'h00; s_flags[0] = SS;
        s_data[1] = 8'h61; s_flags[1] = SMALL | HEX | VOW;
        s_data[2] = 8'h62; s_flags[2] = SMALL | HEX | CONS;
        s_data[3] = 8'h00; s_flags[3] = SS;
        run_a();
        check("sym_count", 32'(a_sym), 32'd4);
        check("str_count", 32'(a_str), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sym_classifier.md
Name: sym_classifier

Overview:
Front-end stage that feeds the string-recognizer FSM. It takes raw bytes from the UART receiver, buffers them in a small FIFO and classifies each byte into the character-class flags. It presents one classified symbol per `valid` pulse, paced so the FSM can register `next_state` between symbols. It also generates `error_verify`, which lets the FSM leave ERROR when the error was caused by the terminating \0 itself.

Parameters:
DEPTH, 4, FIFO depth in bytes (power of two, >=2)
GAP, 1, minimum idle cycles between consecutive `valid` pulses (0..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
rx_data  in  8  byte from UART RX
rx_valid  in  1  one-cycle strobe, rx_data is valid
valid  out  1  one-cycle pulse, flags carry a new symbol
error_verify  out  1  last delivered symbol was \0
overflow  out  1  sticky: a byte was dropped on a full FIFO
start_stop, small_letter, capital_letter, number, hex_digit, punctuation_basic, punctuation_finance, parentheses, curly_braces, math_symbol, whitespace, vowel, consonant, other  out  1 each  class flags of the current symbol

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO empty, gap counter 0.
  - valid=0, error_verify=0, overflow=0.
  - All class flags 0.
- FIFO push:
  - rx_valid=1 and FIFO not full: rx_data is written.
  - rx_valid=1 and FIFO full: the byte is accepted only if a pop occurs in the same cycle. Otherwise it is dropped and overflow is set to 1, held until reset.
- Gap counter:
  - Loaded with GAP on every pop.
  - Decrements to 0 when nonzero.
- Pop condition: FIFO non-empty and gap counter == 0.
- On pop:
  - The next cycle shows valid=1 for exactly one cycle.
  - Flags for the popped byte are registered in the same cycle and held until the next pop. They are not cleared when valid drops.
- Latency: rx_valid in cycle N with an empty FIFO and gap counter 0 gives valid=1 in cycle N+2.
- Spacing: consecutive valid pulses are separated by >= GAP idle cycles. With GAP=0, back-to-back pulses are allowed.
- error_verify:
  - Updated on each pop to (byte == 0x00), then held.
  - Reset clears it.
- Flag decode (several flags may be 1 at once):
  - start_stop: 0x00
  - small_letter: 0x61-0x7A
  - capital_letter: 0x41-0x5A
  - number: 0x30-0x39
  - hex_digit: 0x30-0x39, 0x41-0x46, 0x61-0x66
  - punctuation_basic: . , : ; ! ? ' " (0x2E 0x2C 0x3A 0x3B 0x21 0x3F 0x27 0x22)
  - punctuation_finance: # $ % & @ (0x23-0x26, 0x40)
  - parentheses: ( ) [ ] (0x28 0x29 0x5B 0x5D)
  - curly_braces: { } (0x7B 0x7D)
  - math_symbol: + - * / \ = < > (0x2B 0x2D 0x2A 0x2F 0x5C 0x3D 0x3C 0x3E)
  - whitespace: 0x20 0x09 0x0A 0x0D
  - vowel: a e i o u A E I O U
  - consonant: small_letter|capital_letter and not vowel
  - other: 1 when none of start_stop, small_letter, capital_letter, number, punctuation_basic, punctuation_finance, parentheses, curly_braces, math_symbol, whitespace is 1. This includes 0x80-0xFF and control codes other than whitespace.
- Reset mid-stream: FIFO contents are discarded. No valid pulse appears in the cycle after reset is released.

Optional Feature:
SYM_CLASSIFIER_STATS_EN
- Defined:
  - Adds output sym_count[15:0]: number of popped bytes, saturating at 0xFFFF.
  - Adds output str_count[7:0]: number of popped 0x00 bytes, wrapping.
  - Both cleared by reset.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then rx_valid with 0x24 in cycle 5 -> valid=1 in cycle 7 only; punctuation_finance=1, all other flags 0; error_verify=0.
- Stream 0x00,'$','1','2','3','+','A','B',0x00 at 1 byte per cycle, GAP=1 -> 9 valid pulses, each separated by exactly 1 idle cycle. Flags in order: start_stop; finance; number+hex_digit (x3); math_symbol; capital+hex_digit+vowel; capital+hex_digit+consonant; start_stop. error_verify=1 after the last pulse.
- DEPTH=4, GAP=15, push 6 bytes on consecutive cycles -> 5 bytes delivered (the first pop frees one slot), the 6th dropped; overflow=1 and held until reset.
- Bytes 0x7B, 0x5C, 0x09, 0xC8, 0x65 -> curly_braces; math_symbol; whitespace; other; small_letter+hex_digit+vowel.
- Reset asserted with 3 bytes queued -> after release, no valid pulse; all flags 0; error_verify=0; overflow=0.
- With SYM_CLASSIFIER_STATS_EN, stream "\0ab\0" -> sym_count=4, str_count=2.
